wb_blockram_mp: RTL and testbench

Parametrised multi-port Wishbone block RAM. Up to eight Wishbone slave ports share one simple-dual-port RAM: one read channel and one write channel, each arbitrated independently every cycle. Port 0 can be given fixed priority for a latency-critical master such as the CPU bridge, and each port has selectable byte-lane swapping. It replaces fixed-geometry 4+1-port RAM/arbiter pairs in the opencore fabric.

---
 rtl/wb_blockram_mp.sv | 177 +++++++++++++++++
 tb/tb_wb_blockram_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_blockram_mp.sv
// wb_blockram_mp: multi-port Wishbone block RAM.
// Up to eight slave ports share one simple-dual-port 32-bit RAM. The read
// channel and the write channel each grant at most one port per cycle, so one
// read and one write can complete together. Port 0 can take fixed priority,
// and any port can have its byte lanes reversed.
module wb_blockram_mp #(
  parameter int                NPORTS      = 5,
  parameter int                AW          = 11,
  parameter int                PRIO0       = 1,
  parameter logic [NPORTS-1:0] ENDIAN_SWAP = {NPORTS{1'b0}}
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [32*NPORTS-1:0]  wb_adr_i,
  input  logic [32*NPORTS-1:0]  wb_dat_i,
  output logic [32*NPORTS-1:0]  wb_dat_o,
  input  logic [4*NPORTS-1:0]   wb_sel_i,
  input  logic [NPORTS-1:0]     wb_cyc_i,
  input  logic [NPORTS-1:0]     wb_stb_i,
  input  logic [NPORTS-1:0]     wb_we_i,
  output logic [NPORTS-1:0]     wb_ack_o
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // With port 0 prioritised the round-robin pointer never rests on port 0.
  localparam logic [PW-1:0] PTR_RST = (PRIO0 != 0) ? PW'(1) : PW'(0);

  // Reverse the four bytes of a 32-bit word.
  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Reverse a 4-bit byte-select so it follows a byte-reversed word.
  function automatic logic [3:0] sel_rev(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  // Pick the winner {valid, index}: port 0 first when prioritised, otherwise
  // the first requester at or above ptr, wrapping. The loop walks from the
  // farthest candidate to the nearest so the nearest one overrides.
  function automatic logic [PW:0] arbitrate(input logic [NPORTS-1:0] req,
                                            input logic [PW-1:0]     ptr);
    logic [PW:0] res;
    int          idx;
    res = {(PW+1){1'b0}};
    if ((PRIO0 != 0) && req[0]) begin
      res = {1'b1, {PW{1'b0}}};
    end else begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        idx = int'(ptr) + i;
        if (idx >= NPORTS) begin
          idx = idx - NPORTS;
        end else begin
          idx = idx;
        end
        if (req[idx]) begin
          res = {1'b1, PW'(idx)};
        end else begin
          res = res;
        end
      end
    end
    return res;
  endfunction

  // Pointer value after granting port k: k+1 wrapping, skipping 0 if prioritised.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] k);
    int n;
    n = int'(k) + 1;
    if (n >= NPORTS) begin
      n = 0;
    end else begin
      n = n;
    end
    if ((PRIO0 != 0) && (n == 0)) begin
      n = 1;
    end else begin
      n = n;
    end
    return PW'(n);
  endfunction

  logic [31:0]          mem_r [0:(2**AW)-1];
  logic [NPORTS-1:0]    ack_r;
  logic [32*NPORTS-1:0] dat_r;
  logic [PW-1:0]        rd_ptr_r, wr_ptr_r;

  logic [NPORTS-1:0]    rd_req_s, wr_req_s, rd_gnt_s, wr_gnt_s;
  logic                 rd_vld_s, wr_vld_s, wr_en_s;
  logic [PW-1:0]        rd_idx_s, wr_idx_s, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [AW-1:0]        rd_word_s, wr_word_s;
  logic [31:0]          wr_raw_s, wr_data_s, rd_raw_s;
  logic [3:0]           wr_sel_raw_s, wr_sel_s;
  logic                 adr_unused_s;

  // Address bits outside the word index are intentionally ignored (aliasing).
  assign adr_unused_s = ^wb_adr_i;

  // Request decode, arbitration, write-data steering and pointer advance.
  always_comb begin
    rd_req_s = {NPORTS{1'b0}};
    wr_req_s = {NPORTS{1'b0}};
    for (int n = 0; n < NPORTS; n++) begin
      // A port is masked in its own ack cycle, giving a 2-cycle minimum period.
      rd_req_s[n] = wb_cyc_i[n] & wb_stb_i[n] & ~wb_we_i[n] & ~ack_r[n];
      wr_req_s[n] = wb_cyc_i[n] & wb_stb_i[n] &  wb_we_i[n] & ~ack_r[n];
    end

    {rd_vld_s, rd_idx_s} = arbitrate(rd_req_s, rd_ptr_r);
    {wr_vld_s, wr_idx_s} = arbitrate(wr_req_s, wr_ptr_r);

    rd_gnt_s = rd_vld_s ? ({{(NPORTS-1){1'b0}}, 1'b1} << rd_idx_s) : {NPORTS{1'b0}};
    wr_gnt_s = wr_vld_s ? ({{(NPORTS-1){1'b0}}, 1'b1} << wr_idx_s) : {NPORTS{1'b0}};

    rd_word_s    = wb_adr_i[32*int'(rd_idx_s) + 2 +: AW];
    wr_word_s    = wb_adr_i[32*int'(wr_idx_s) + 2 +: AW];
    wr_raw_s     = wb_dat_i[32*int'(wr_idx_s) +: 32];
    wr_sel_raw_s = wb_sel_i[4*int'(wr_idx_s) +: 4];
    if (ENDIAN_SWAP[wr_idx_s]) begin
      wr_data_s = byte_rev(wr_raw_s);
      wr_sel_s  = sel_rev(wr_sel_raw_s);
    end else begin
      wr_data_s = wr_raw_s;
      wr_sel_s  = wr_sel_raw_s;
    end

    // Reset suppresses any grant: no RAM write, no ack.
    wr_en_s  = wr_vld_s & ~wb_rst_i;
    // Read-before-write: the read port sees the contents before this edge.
    rd_raw_s = mem_r[rd_word_s];

    if (rd_vld_s && !((PRIO0 != 0) && (rd_idx_s == {PW{1'b0}}))) begin
      rd_ptr_nxt_s = advance(rd_idx_s);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (wr_vld_s && !((PRIO0 != 0) && (wr_idx_s == {PW{1'b0}}))) begin
      wr_ptr_nxt_s = advance(wr_idx_s);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
  end

  // RAM write with per-byte enables; contents are never reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_sel_s[b]) begin
          mem_r[wr_word_s][8*b +: 8] <= wr_data_s[8*b +: 8];
        end
      end
    end
  end

  // Acks, per-port read-data hold registers and the two round-robin pointers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r    <= {NPORTS{1'b0}};
      dat_r    <= {(32*NPORTS){1'b0}};
      rd_ptr_r <= PTR_RST;
      wr_ptr_r <= PTR_RST;
    end else begin
      ack_r    <= rd_gnt_s | wr_gnt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      for (int n = 0; n < NPORTS; n++) begin
        if (rd_gnt_s[n]) begin
          dat_r[32*n +: 32] <= ENDIAN_SWAP[n] ? byte_rev(rd_raw_s) : rd_raw_s;
        end
      end
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_dat_o = dat_r;

endmodule

// File: tb/tb_wb_blockram_mp.sv
// Directed self-checking bench for wb_blockram_mp (5 ports, port 0 priority,
// port 1 byte-swapped).
module tb_wb_blockram_mp;

  localparam int NP = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*NP-1:0] adr, dat_i, dat_o;
  logic [4*NP-1:0]  sel;
  logic [NP-1:0]    cyc, stb, we, ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_blockram_mp #(
    .NPORTS(NP), .AW(11), .PRIO0(1), .ENDIAN_SWAP(5'b00010)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_sel_i(sel),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cyc[p] = 1'b1;
    stb[p] = 1'b1;
    we[p]  = w;
    adr[32*p +: 32]   = a;
    dat_i[32*p +: 32] = d;
    sel[4*p +: 4]     = s;
  endtask

  task automatic clr_req(input int p);
    cyc[p] = 1'b0;
    stb[p] = 1'b0;
    we[p]  = 1'b0;
  endtask

  task automatic clr_all();
    for (int p = 0; p < NP; p++) clr_req(p);
  endtask

  // One isolated transfer: capture ack and read data in the cycle after stb.
  task automatic xfer(input int p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [NP-1:0] ack_seen, output logic [31:0] rd_seen);
    set_req(p, w, a, d, s);
    step();
    ack_seen = ack;
    rd_seen  = dat_o[32*p +: 32];
    clr_req(p);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (ack !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ack: got %b expected %b", ack, 5'b00000);
    end
    n_checks++;
    if (dat_o !== {(32*NP){1'b0}}) begin
      n_fail++; $display("FAIL reset_dat: got %h expected 0", dat_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [NP-1:0] a;
    logic [31:0]   r;
    set_req(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    step();
    n_checks++;
    if (ack !== 5'b00100) begin
      n_fail++; $display("FAIL single_wr_ack: got %b expected %b", ack, 5'b00100);
    end
    clr_req(2);
    step();
    n_checks++;
    if (ack !== 5'b00000) begin
      n_fail++; $display("FAIL single_ack_pulse: got %b expected %b", ack, 5'b00000);
    end
    xfer(2, 1'b0, 32'h10, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (a !== 5'b00100) begin
      n_fail++; $display("FAIL single_rd_ack: got %b expected %b", a, 5'b00100);
    end
    n_checks++;
    if (r !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_rd_data: got %h expected %h", r, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_swap();
    logic [NP-1:0] a;
    logic [31:0]   r;
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'b1111, a, r);
    xfer(0, 1'b1, 32'h0, 32'hAA000000, 4'b1000, a, r);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'hAA223344) begin
      n_fail++; $display("FAIL lane_p0_read: got %h expected %h", r, 32'hAA223344);
    end
    xfer(1, 1'b0, 32'h0, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h443322AA || a !== 5'b00010) begin
      n_fail++; $display("FAIL swap_p1_read: got %h ack %b expected %h ack 00010", r, a, 32'h443322AA);
    end
    xfer(1, 1'b1, 32'h24, 32'hCAFEF00D, 4'b1111, a, r);
    xfer(0, 1'b0, 32'h24, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h0DF0FECA) begin
      n_fail++; $display("FAIL swap_p1_write: got %h expected %h", r, 32'h0DF0FECA);
    end
    xfer(1, 1'b1, 32'h24, 32'h000000EE, 4'b0001, a, r);
    xfer(0, 1'b0, 32'h24, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'hEEF0FECA) begin
      n_fail++; $display("FAIL swap_p1_sel: got %h expected %h", r, 32'hEEF0FECA);
    end
  endtask

  task automatic test_round_robin();
    int            seq_b [8] = '{0, 1, 0, 2, 0, 3, 0, 4};
    logic [NP-1:0] exp;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 1; p < NP; p++) set_req(p, 1'b0, 32'h100 + 32'(4*p), 32'h0, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      step();
      exp = 5'b00001 << ((i % 4) + 1);
      n_checks++;
      if (ack !== exp) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", i, ack, exp);
      end
    end
    set_req(0, 1'b0, 32'h100, 32'h0, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      step();
      exp = 5'b00001 << seq_b[i];
      n_checks++;
      if (ack !== exp) begin
        n_fail++; $display("FAIL rr_prio0[%0d]: got %b expected %b", i, ack, exp);
      end
    end
    clr_all();
    step();
    step();
  endtask

  task automatic test_concurrent();
    logic [NP-1:0] a;
    logic [31:0]   r;
    xfer(3, 1'b1, 32'h40, 32'h00000077, 4'b1111, a, r);
    set_req(3, 1'b1, 32'h40, 32'h00000005, 4'b1111);
    set_req(4, 1'b0, 32'h40, 32'h0, 4'b1111);
    step();
    n_checks++;
    if (ack !== 5'b11000) begin
      n_fail++; $display("FAIL conc_ack: got %b expected %b", ack, 5'b11000);
    end
    n_checks++;
    if (dat_o[32*4 +: 32] !== 32'h00000077) begin
      n_fail++; $display("FAIL conc_old_data: got %h expected %h", dat_o[32*4 +: 32], 32'h77);
    end
    clr_all();
    step();
    xfer(4, 1'b0, 32'h40, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h00000005) begin
      n_fail++; $display("FAIL conc_new_data: got %h expected %h", r, 32'h5);
    end
  endtask

  task automatic test_alias();
    logic [NP-1:0] a;
    logic [31:0]   r;
    xfer(2, 1'b1, 32'h00002008, 32'h12345678, 4'b1111, a, r);
    xfer(2, 1'b0, 32'h00000008, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h12345678) begin
      n_fail++; $display("FAIL alias_read: got %h expected %h", r, 32'h12345678);
    end
    xfer(3, 1'b0, 32'h0000000B, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h12345678) begin
      n_fail++; $display("FAIL alias_low_bits: got %h expected %h", r, 32'h12345678);
    end
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] exp;
    set_req(2, 1'b0, 32'h8, 32'h0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      step();
      exp = (i % 2 == 0) ? 5'b00100 : 5'b00000;
      n_checks++;
      if (ack !== exp) begin
        n_fail++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, ack, exp);
      end
    end
    clr_all();
    step();
  endtask

  task automatic test_reset_grant();
    logic [NP-1:0] a;
    logic [31:0]   r;
    xfer(2, 1'b1, 32'h30, 32'h00000099, 4'b1111, a, r);
    // Leave the read pointer at port 4 so a restart at port 1 is visible.
    xfer(3, 1'b0, 32'h30, 32'h0, 4'b1111, a, r);
    set_req(2, 1'b1, 32'h30, 32'h00000BAD, 4'b1111);
    set_req(3, 1'b0, 32'h30, 32'h0, 4'b1111);
    rst = 1'b1;
    step();
    n_checks++;
    if (ack !== 5'b00000) begin
      n_fail++; $display("FAIL rst_grant_ack: got %b expected %b", ack, 5'b00000);
    end
    rst = 1'b0;
    clr_all();
    for (int p = 1; p < NP; p++) set_req(p, 1'b0, 32'h30, 32'h0, 4'b1111);
    step();
    n_checks++;
    if (ack !== 5'b00010) begin
      n_fail++; $display("FAIL rst_ptr_restart: got %b expected %b", ack, 5'b00010);
    end
    clr_all();
    step();
    step();
    xfer(2, 1'b0, 32'h30, 32'h0, 4'b1111, a, r);
    n_checks++;
    if (r !== 32'h00000099) begin
      n_fail++; $display("FAIL rst_no_write: got %h expected %h", r, 32'h99);
    end
  endtask

  initial begin
    rst   = 1'b1;
    adr   = {(32*NP){1'b0}};
    dat_i = {(32*NP){1'b0}};
    sel   = {(4*NP){1'b0}};
    cyc   = {NP{1'b0}};
    stb   = {NP{1'b0}};
    we    = {NP{1'b0}};
    test_reset();
    test_single();
    test_byte_swap();
    test_round_robin();
    test_concurrent();
    test_alias();
    test_back_to_back();
    test_reset_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
